is31_i2c_target: RTL and testbench

I²C target (responder) that emulates the register interface of the Scroll Hat Mini's IS31FL3731 LED driver at a fixed 7-bit address. It decodes bus traffic, including 0xFD page-select writes, auto-incrementing multi-byte writes and reads. It presents each register write and read to a local register file through a simple strobe interface. It is the bus-side counterpart of the I2C_CONTROLLER used by the display driver. It serves as an on-FPGA stand-in for the hat during loopback bring-up and in simulation.

---
 rtl/is31_i2c_pkg.sv | 23 ++
 rtl/is31_i2c_bus_monitor.sv | 54 +++++
 rtl/is31_i2c_target.sv | 233 +++++++++++++++++++++++
 tb/tb_is31_i2c_target.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/is31_i2c_pkg.sv
// Shared types and register constants for the IS31FL3731 I2C target emulation.
`timescale 1ns/1ps
package is31_i2c_pkg;

    // Bus-side protocol states of the target.
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        LOC,
        LOC_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // Writing to this location selects the page instead of touching a register.
    localparam logic [7:0] LOC_COMMAND_REGISTER   = 8'hFD;
    // Page holding the function registers (configuration, shutdown, ...).
    localparam logic [7:0] PAGE_FUNCTION_REGISTER = 8'h0B;

endpackage

// File: rtl/is31_i2c_bus_monitor.sv
// Synchronizes raw SCL/SDA and turns them into single-cycle bus event strobes.
`timescale 1ns/1ps
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_level
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchronizer chains reset to the idle-high bus level so leaving reset
    // never produces a phantom edge; strobes are registered, giving a
    // pin-to-strobe latency of SYNC_STAGES+1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_prev  <= 1'b1;
            sda_prev  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start     <= 1'b0;
            stop      <= 1'b0;
            sda_level <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_prev  <= scl_s;
            sda_prev  <= sda_s;
            scl_rise  <= scl_s & ~scl_prev;
            scl_fall  <= ~scl_s & scl_prev;
            start     <= scl_s & scl_prev & sda_prev & ~sda_s;
            stop      <= scl_s & scl_prev & ~sda_prev & sda_s;
            sda_level <= sda_s;
        end
    end

endmodule

// File: rtl/is31_i2c_target.sv
// I2C target emulating the IS31FL3731 register interface: page select via 0xFD,
// auto-incrementing writes and reads, presented as register-file strobes.
//
// Local strobe interface: wr_valid and rd_req are single-cycle strobes with no
// back-pressure (there is no ready); wr_* stay stable until the next wr_valid,
// rd_page/rd_addr until the next rd_req, and rd_data is sampled exactly one
// cycle after rd_req.
`timescale 1ns/1ps
module is31_i2c_target
    import is31_i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h74,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_e,
    output logic [7:0] page,
    output logic       wr_valid,
    output logic [7:0] wr_page,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_req,
    output logic [7:0] rd_page,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       active,
    output state_t     state_dbg
);

    logic scl_rise, scl_fall, start, stop, sda_level;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop),
        .sda_level (sda_level)
    );

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] loc, loc_n;
    logic [7:0] page_n;
    logic       rw, rw_n;
    logic       sda_e_n, active_n, rd_pend;
    logic       wr_valid_n, rd_req_n;
    logic [7:0] wr_page_n, wr_addr_n, wr_data_n, rd_page_n, rd_addr_n;
    logic [7:0] byte_in;

    assign sda_o     = 1'b0;
    assign state_dbg = state;
    assign byte_in   = {shreg[6:0], sda_level};

    // Register all protocol state; async reset releases SDA immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            shreg    <= 8'h00;
            loc      <= 8'h00;
            page     <= 8'h00;
            rw       <= 1'b0;
            sda_e    <= 1'b0;
            active   <= 1'b0;
            rd_pend  <= 1'b0;
            wr_valid <= 1'b0;
            wr_page  <= 8'h00;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            rd_req   <= 1'b0;
            rd_page  <= 8'h00;
            rd_addr  <= 8'h00;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            loc      <= loc_n;
            page     <= page_n;
            rw       <= rw_n;
            sda_e    <= sda_e_n;
            active   <= active_n;
            rd_pend  <= rd_req;
            wr_valid <= wr_valid_n;
            wr_page  <= wr_page_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            rd_req   <= rd_req_n;
            rd_page  <= rd_page_n;
            rd_addr  <= rd_addr_n;
        end
    end

    // Next-state and datapath decisions, driven by the bus event strobes.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        loc_n      = loc;
        page_n     = page;
        rw_n       = rw;
        sda_e_n    = sda_e;
        active_n   = active;
        wr_valid_n = 1'b0;
        wr_page_n  = wr_page;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        rd_req_n   = 1'b0;
        rd_page_n  = rd_page;
        rd_addr_n  = rd_addr;

        // Read data arrives one cycle after the request; the pointer advances
        // only once the byte is actually fetched.
        if (rd_pend) begin
            shreg_n = rd_data;
            loc_n   = loc + 8'd1;
        end

        if (stop) begin
            state_n  = IDLE;
            sda_e_n  = 1'b0;
            active_n = 1'b0;
            cnt_n    = 3'd0;
        end else if (start) begin
            // A partial byte is simply dropped: nothing was committed yet.
            state_n  = ADDR;
            sda_e_n  = 1'b0;
            active_n = 1'b0;
            cnt_n    = 3'd0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (byte_in[7:1] == ADDRESS) begin
                                state_n  = ADDR_ACK;
                                rw_n     = byte_in[0];
                                active_n = 1'b1;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                ADDR_ACK, LOC_ACK, WDATA_ACK: begin
                    // First fall after the byte pulls SDA low, the next one releases.
                    if (scl_fall) begin
                        if (!sda_e) begin
                            sda_e_n = 1'b1;
                        end else begin
                            sda_e_n = 1'b0;
                            state_n = (state == ADDR_ACK) ? LOC : WDATA;
                        end
                    end else if (scl_rise && sda_e && rw && state == ADDR_ACK) begin
                        // Read: fetch the first byte during the ACK high phase so
                        // it is ready for the fall that ends the ACK.
                        rd_req_n  = 1'b1;
                        rd_page_n = page;
                        rd_addr_n = loc;
                        state_n   = RDATA;
                        cnt_n     = 3'd0;
                    end
                end
                LOC: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            loc_n   = byte_in;
                            state_n = LOC_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_n = byte_in;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            if (loc == LOC_COMMAND_REGISTER) begin
                                page_n = byte_in;
                            end else begin
                                wr_valid_n = 1'b1;
                                wr_page_n  = page;
                                wr_addr_n  = loc;
                                wr_data_n  = byte_in;
                            end
                            loc_n   = loc + 8'd1;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_e_n = ~shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) state_n = RDATA_ACK;
                    end
                end
                RDATA_ACK: begin
                    // cnt==1 marks that SDA was released, so the next rise is the
                    // master's ACK bit rather than the tail of data bit 0.
                    if (scl_fall) begin
                        sda_e_n = 1'b0;
                        cnt_n   = 3'd1;
                    end else if (scl_rise && cnt == 3'd1) begin
                        cnt_n = 3'd0;
                        if (!sda_level) begin
                            rd_req_n  = 1'b1;
                            rd_page_n = page;
                            rd_addr_n = loc;
                            state_n   = RDATA;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_is31_i2c_target.sv
// Self-checking bench: an I2C master driver, a register-file responder and a
// high-level model of the expected register transactions.
`timescale 1ns/1ps
module tb_is31_i2c_target;
    import is31_i2c_pkg::*;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_o, sda_e, wr_valid, rd_req, active;
    logic [7:0] page, wr_page, wr_addr, wr_data, rd_page, rd_addr, rd_data;
    state_t     state_dbg;
    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  tx_q[$];
    logic [23:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];
    logic [7:0]  exp_dat_q[$];
    logic [7:0]  got_dat_q[$];
    logic [23:0] got_wr_q[$];
    logic [15:0] got_rd_q[$];
    int          sda_e_cycles = 0;
    int          active_cycles = 0;
    logic [7:0]  m_page = 8'h00;
    logic [7:0]  m_loc = 8'h00;

    assign sda_line = m_sda & ~sda_e;
    assign rd_data  = mem[rd_addr];

    always #10 clk = ~clk;

    is31_i2c_target dut (
        .clk(clk), .reset(reset), .scl_i(m_scl), .sda_i(sda_line),
        .sda_o(sda_o), .sda_e(sda_e), .page(page),
        .wr_valid(wr_valid), .wr_page(wr_page), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_page(rd_page), .rd_addr(rd_addr), .rd_data(rd_data),
        .active(active), .state_dbg(state_dbg)
    );

    // Monitor: log every strobe seen on the local side.
    always @(negedge clk) begin
        if (wr_valid) got_wr_q.push_back({wr_page, wr_addr, wr_data});
        if (rd_req) got_rd_q.push_back({rd_page, rd_addr});
        if (sda_e) sda_e_cycles++;
        if (active) active_cycles++;
    end

    initial begin
        #1_600_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- model ----------------
    task automatic model_write(input logic [7:0] loc);
        m_loc = loc;
        foreach (tx_q[i]) begin
            if (m_loc == LOC_COMMAND_REGISTER) m_page = tx_q[i];
            else exp_wr_q.push_back({m_page, m_loc, tx_q[i]});
            m_loc = m_loc + 8'd1;
        end
    endtask

    task automatic model_read(input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back({m_page, m_loc});
            exp_dat_q.push_back(mem[m_loc]);
            m_loc = m_loc + 8'd1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic hq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hq(); m_scl = 1'b1; hq(); m_sda = 1'b0; hq(); m_scl = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hq(); m_scl = 1'b1; hq(); m_sda = 1'b1; hq();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; hq(); m_scl = 1'b1; hq(); hq(); m_scl = 1'b0; hq();
        end
    endtask

    task automatic i2c_write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; hq(); m_scl = 1'b1; hq(); ack = sda_line; hq(); m_scl = 1'b0; hq();
    endtask

    task automatic i2c_read_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            hq(); m_scl = 1'b1; hq(); b[i] = sda_line; hq(); m_scl = 1'b0;
        end
        hq();
        m_sda = nack; hq(); m_scl = 1'b1; hq(); hq(); m_scl = 1'b0; hq();
        m_sda = 1'b1;
    endtask

    task automatic do_write(input logic [7:0] loc, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        i2c_write_byte({7'h74, 1'b0}, a); if (!a) acks++;
        i2c_write_byte(loc, a); if (!a) acks++;
        foreach (tx_q[i]) begin
            i2c_write_byte(tx_q[i], a); if (!a) acks++;
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] loc, input int n);
        logic a;
        logic [7:0] b;
        i2c_start();
        i2c_write_byte({7'h74, 1'b0}, a);
        i2c_write_byte(loc, a);
        i2c_start();
        i2c_write_byte({7'h74, 1'b1}, a);
        for (int i = 0; i < n; i++) begin
            i2c_read_byte(i == n - 1, b);
            got_dat_q.push_back(b);
        end
        i2c_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (sda_e !== 1'b0) begin n_err++; $display("FAIL rst_sda_e got %b exp 0", sda_e); end
        n_cmp++; if (sda_o !== 1'b0) begin n_err++; $display("FAIL rst_sda_o got %b exp 0", sda_o); end
        n_cmp++; if (page !== 8'h00) begin n_err++; $display("FAIL rst_page got %h exp 00", page); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid got %b exp 0", wr_valid); end
        n_cmp++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL rst_rd_req got %b exp 0", rd_req); end
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL rst_active got %b exp 0", active); end
        n_cmp++; if ({wr_page, wr_addr, wr_data} !== 24'h0) begin n_err++; $display("FAIL rst_wr_fields got %h exp 000000", {wr_page, wr_addr, wr_data}); end
        n_cmp++; if ({rd_page, rd_addr} !== 16'h0) begin n_err++; $display("FAIL rst_rd_fields got %h exp 0000", {rd_page, rd_addr}); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL rst_state got %0d exp %0d", state_dbg, IDLE); end
    endtask

    task automatic test_page_select();
        int acks, wb;
        wb = got_wr_q.size();
        tx_q = '{PAGE_FUNCTION_REGISTER};
        model_write(LOC_COMMAND_REGISTER);
        do_write(LOC_COMMAND_REGISTER, acks);
        n_cmp++; if (page !== 8'h0B) begin n_err++; $display("FAIL page_sel page got %h exp 0b", page); end
        n_cmp++; if (page !== m_page) begin n_err++; $display("FAIL page_sel model got %h exp %h", page, m_page); end
        n_cmp++; if (got_wr_q.size() - wb !== 0) begin n_err++; $display("FAIL page_sel wr_count got %0d exp 0", got_wr_q.size() - wb); end
        n_cmp++; if (acks !== 3) begin n_err++; $display("FAIL page_sel acks got %0d exp 3", acks); end
    endtask

    task automatic test_burst_write(input logic [7:0] loc, input string name);
        int acks, wb;
        wb = got_wr_q.size();
        exp_wr_q.delete();
        model_write(loc);
        do_write(loc, acks);
        n_cmp++; if (acks !== 2 + tx_q.size()) begin n_err++; $display("FAIL %s acks got %0d exp %0d", name, acks, 2 + tx_q.size()); end
        n_cmp++; if (got_wr_q.size() - wb !== exp_wr_q.size()) begin n_err++; $display("FAIL %s wr_count got %0d exp %0d", name, got_wr_q.size() - wb, exp_wr_q.size()); end
        foreach (exp_wr_q[i]) begin
            n_cmp++;
            if (got_wr_q.size() <= wb + i || got_wr_q[wb + i] !== exp_wr_q[i]) begin
                n_err++; $display("FAIL %s wr[%0d] got %h exp %h", name, i, got_wr_q[wb + i], exp_wr_q[i]);
            end
        end
        n_cmp++; if (page !== m_page) begin n_err++; $display("FAIL %s page got %h exp %h", name, page, m_page); end
    endtask

    task automatic test_wrong_address();
        logic [6:0] a;
        logic ack;
        int wb, rb, sb, ab;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 7'h75 : 7'($urandom_range(0, 127));
            if (a == 7'h74) a = 7'h33;
            wb = got_wr_q.size(); rb = got_rd_q.size(); sb = sda_e_cycles; ab = active_cycles;
            i2c_start();
            i2c_write_byte({a, 1'($urandom_range(0, 1))}, ack);
            i2c_write_byte(8'($urandom_range(0, 255)), ack);
            i2c_stop();
            n_cmp++; if (sda_e_cycles - sb !== 0) begin n_err++; $display("FAIL wrong_addr %h sda_e_cycles got %0d exp 0", a, sda_e_cycles - sb); end
            n_cmp++; if (active_cycles - ab !== 0) begin n_err++; $display("FAIL wrong_addr %h active_cycles got %0d exp 0", a, active_cycles - ab); end
            n_cmp++; if ((got_wr_q.size() - wb) + (got_rd_q.size() - rb) !== 0) begin n_err++; $display("FAIL wrong_addr %h strobes got %0d exp 0", a, (got_wr_q.size() - wb) + (got_rd_q.size() - rb)); end
        end
    endtask

    task automatic test_read_check(input string name, input int rb);
        n_cmp++; if (got_rd_q.size() - rb !== exp_rd_q.size()) begin n_err++; $display("FAIL %s rd_count got %0d exp %0d", name, got_rd_q.size() - rb, exp_rd_q.size()); end
        foreach (exp_rd_q[i]) begin
            n_cmp++;
            if (got_rd_q.size() <= rb + i || got_rd_q[rb + i] !== exp_rd_q[i]) begin
                n_err++; $display("FAIL %s rd[%0d] got %h exp %h", name, i, got_rd_q[rb + i], exp_rd_q[i]);
            end
            n_cmp++;
            if (got_dat_q.size() <= i || got_dat_q[i] !== exp_dat_q[i]) begin
                n_err++; $display("FAIL %s data[%0d] got %h exp %h", name, i, got_dat_q[i], exp_dat_q[i]);
            end
        end
    endtask

    task automatic test_read();
        int rb;
        rb = got_rd_q.size();
        exp_rd_q.delete(); exp_dat_q.delete(); got_dat_q.delete();
        mem[8'h10] = 8'h5A; mem[8'h11] = 8'hC3;
        m_loc = 8'h10;
        model_read(2);
        do_read(8'h10, 2);
        test_read_check("read", rb);
        n_cmp++; if (got_dat_q.size() != 2 || got_dat_q[0] !== 8'h5A || got_dat_q[1] !== 8'hC3) begin n_err++; $display("FAIL read_const got %0d bytes exp 5a c3", got_dat_q.size()); end
        n_cmp++; if (got_rd_q.size() != rb + 2 || got_rd_q[rb][7:0] !== 8'h10 || got_rd_q[rb + 1][7:0] !== 8'h11) begin n_err++; $display("FAIL read_addrs got %0d reqs exp 10 11", got_rd_q.size() - rb); end
        n_cmp++; if (sda_e !== 1'b0 || sda_line !== 1'b1) begin n_err++; $display("FAIL read_release sda_e got %b exp 0", sda_e); end
    endtask

    task automatic test_abort();
        logic [7:0] loc;
        logic [7:0] b;
        logic a;
        int wb, rb;
        loc = 8'($urandom_range(0, 8'hF0));
        wb = got_wr_q.size(); rb = got_rd_q.size();
        exp_wr_q.delete(); exp_rd_q.delete(); exp_dat_q.delete(); got_dat_q.delete();
        tx_q = '{8'($urandom_range(0, 255))};
        model_write(loc);
        model_read(1);
        i2c_start();
        i2c_write_byte({7'h74, 1'b0}, a);
        i2c_write_byte(loc, a);
        i2c_write_byte(tx_q[0], a);
        send_bits(8'($urandom_range(0, 255)), 4);
        i2c_start();
        i2c_write_byte({7'h74, 1'b1}, a);
        i2c_read_byte(1'b1, b);
        got_dat_q.push_back(b);
        i2c_stop();
        n_cmp++; if (got_wr_q.size() - wb !== 1 || got_wr_q[wb] !== exp_wr_q[0]) begin n_err++; $display("FAIL abort wr got %0d entries exp 1 (%h)", got_wr_q.size() - wb, exp_wr_q[0]); end
        test_read_check("abort", rb);
    endtask

    task automatic test_random();
        int acks, wb, rb, n;
        logic [7:0] loc;
        for (int it = 0; it < 12; it++) begin
            loc = 8'($urandom_range(0, 255));
            wb = got_wr_q.size(); rb = got_rd_q.size();
            exp_wr_q.delete(); exp_rd_q.delete(); exp_dat_q.delete(); got_dat_q.delete();
            if ($urandom_range(0, 1) == 0) begin
                n = $urandom_range(1, 4);
                tx_q.delete();
                for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
                model_write(loc);
                do_write(loc, acks);
                n_cmp++; if (acks !== 2 + n) begin n_err++; $display("FAIL rand%0d acks got %0d exp %0d", it, acks, 2 + n); end
                n_cmp++; if (got_wr_q.size() - wb !== exp_wr_q.size()) begin n_err++; $display("FAIL rand%0d wr_count got %0d exp %0d", it, got_wr_q.size() - wb, exp_wr_q.size()); end
                foreach (exp_wr_q[i]) begin
                    n_cmp++;
                    if (got_wr_q.size() <= wb + i || got_wr_q[wb + i] !== exp_wr_q[i]) begin
                        n_err++; $display("FAIL rand%0d wr[%0d] got %h exp %h", it, i, got_wr_q[wb + i], exp_wr_q[i]);
                    end
                end
                n_cmp++; if (page !== m_page) begin n_err++; $display("FAIL rand%0d page got %h exp %h", it, page, m_page); end
            end else begin
                n = $urandom_range(1, 3);
                m_loc = loc;
                model_read(n);
                do_read(loc, n);
                test_read_check($sformatf("rand%0d", it), rb);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic a;
        int rb;
        i2c_start();
        send_bits({7'h74, 1'b0}, 8);
        hq();
        n_cmp++; if (sda_e !== 1'b1) begin n_err++; $display("FAIL rstmid ack_driven got %b exp 1", sda_e); end
        @(negedge clk); #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (sda_e !== 1'b0) begin n_err++; $display("FAIL rstmid async_release got %b exp 0", sda_e); end
        @(negedge clk);
        n_cmp++; if (page !== 8'h00 || active !== 1'b0 || state_dbg !== IDLE) begin n_err++; $display("FAIL rstmid page/active/state got %h %b %0d exp 00 0 %0d", page, active, state_dbg, IDLE); end
        n_cmp++; if ({wr_valid, rd_req, sda_o} !== 3'b000) begin n_err++; $display("FAIL rstmid strobes got %b exp 000", {wr_valid, rd_req, sda_o}); end
        n_cmp++; if ({wr_page, wr_addr, wr_data, rd_page, rd_addr} !== 40'h0) begin n_err++; $display("FAIL rstmid fields got %h exp 0", {wr_page, wr_addr, wr_data, rd_page, rd_addr}); end
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        m_page = 8'h00; m_loc = 8'h00;
        // Location pointer must be back at 0: read from the current location.
        rb = got_rd_q.size();
        exp_rd_q.delete(); exp_dat_q.delete(); got_dat_q.delete();
        model_read(1);
        i2c_start();
        i2c_write_byte({7'h74, 1'b1}, a);
        i2c_read_byte(1'b1, b);
        got_dat_q.push_back(b);
        i2c_stop();
        test_read_check("rstmid_read", rb);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        test_reset();
        test_page_select();
        tx_q = '{8'hFF, 8'h00, 8'hAA};
        test_burst_write(8'h24, "burst");
        test_wrong_address();
        tx_q = '{8'h11, 8'h22, 8'h33};
        test_burst_write(8'hFE, "wrap");
        test_read();
        test_abort();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
